// File: rtl/uninasoc_pkg.sv
// uninasoc_pkg: shared SoC constants, GPIO-in register offsets, AXI responses and FSM states.
package uninasoc_pkg;

    localparam int NUM_GPIO_IN = 16;

    localparam logic [4:0] GPIO_IN_DATA_OFFSET = 5'h00;
    localparam logic [4:0] GPIO_IN_IER_OFFSET  = 5'h04;
    localparam logic [4:0] GPIO_IN_ISR_OFFSET  = 5'h08;
    localparam logic [4:0] GPIO_IN_POL_OFFSET  = 5'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/axilite_gpio_in_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser, previous-sample register and polarity-selected
// edge detection, held off until the pipeline has filled after reset.
module sync_edge_detect #(
    parameter int W = 16
) (
    input  logic         clock_i,
    input  logic         reset_ni,
    input  logic [W-1:0] async_i,
    input  logic [W-1:0] pol_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] edge_o
);

    logic [W-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [1:0]   arm_q, arm_d;

    always_comb begin
        s1_d   = async_i;
        s2_d   = s1_q;
        prev_d = s2_q;
        arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    assign sync_o = s2_q;
    assign edge_o = (arm_q == 2'd3) ? ((pol_i & prev_q & ~s2_q) | (~pol_i & s2_q & ~prev_q)) : '0;

endmodule

// File: rtl/axilite_gpio_in.sv
// axilite_gpio_in: AXI-Lite GPIO input peripheral with synchronised DATA, per-bit
// edge events latched into a W1C ISR, enable/polarity registers and a level interrupt.
module axilite_gpio_in
    import uninasoc_pkg::*;
#(
    parameter int NUM_IN     = NUM_GPIO_IN,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic [NUM_IN-1:0]     gpio_in_i,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
    input  logic                  s_axilite_awvalid,
    output logic                  s_axilite_awready,
    input  logic [31:0]           s_axilite_wdata,
    input  logic [3:0]            s_axilite_wstrb,
    input  logic                  s_axilite_wvalid,
    output logic                  s_axilite_wready,
    output logic [1:0]            s_axilite_bresp,
    output logic                  s_axilite_bvalid,
    input  logic                  s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
    input  logic                  s_axilite_arvalid,
    output logic                  s_axilite_arready,
    output logic [31:0]           s_axilite_rdata,
    output logic [1:0]            s_axilite_rresp,
    output logic                  s_axilite_rvalid,
    input  logic                  s_axilite_rready,
    output logic                  irq_o
);

    logic [NUM_IN-1:0] sync, edges;
    logic [NUM_IN-1:0] ier_q, ier_d, isr_q, isr_d, pol_q, pol_d, clr, wm, wd;
    wstate_e           wst_q, wst_d;
    rstate_e           rst_q, rst_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d, wmask, rword;
    logic [4:0]        waddr, raddr;
    logic              irq_q, irq_d, wacc, racc;
    logic              unused_bits;

    sync_edge_detect #(.W(NUM_IN)) u_sed (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .async_i (gpio_in_i),
        .pol_i   (pol_q),
        .sync_o  (sync),
        .edge_o  (edges)
    );

    assign unused_bits = ^{s_axilite_awaddr, s_axilite_araddr, s_axilite_wdata, wmask};

    always_comb begin
        wst_d = (wst_q == W_IDLE && s_axilite_awvalid && s_axilite_wvalid) ? W_RESP :
                (wst_q == W_RESP && s_axilite_bready) ? W_IDLE : wst_q;
        rst_d = (rst_q == R_IDLE && s_axilite_arvalid) ? R_DATA :
                (rst_q == R_DATA && s_axilite_rready) ? R_IDLE : rst_q;
    end

    always_comb begin
        s_axilite_awready = (wst_q == W_IDLE);
        s_axilite_wready  = (wst_q == W_IDLE);
        s_axilite_bvalid  = (wst_q == W_RESP);
        s_axilite_arready = (rst_q == R_IDLE);
        s_axilite_rvalid  = (rst_q == R_DATA);
    end

    always_comb begin
        waddr   = {s_axilite_awaddr[4:2], 2'b00};
        wacc    = (wst_q == W_IDLE) && s_axilite_awvalid && s_axilite_wvalid;
        wmask   = strb_mask(s_axilite_wstrb);
        wm      = wmask[NUM_IN-1:0];
        wd      = s_axilite_wdata[NUM_IN-1:0];
        ier_d   = (wacc && waddr == GPIO_IN_IER_OFFSET) ? (ier_q & ~wm) | (wd & wm) : ier_q;
        pol_d   = (wacc && waddr == GPIO_IN_POL_OFFSET) ? (pol_q & ~wm) | (wd & wm) : pol_q;
        clr     = (wacc && waddr == GPIO_IN_ISR_OFFSET) ? (wd & wm) : '0;
        // Clearing before OR-ing in new edges lets a coincident event survive the W1C.
        isr_d   = (isr_q & ~clr) | edges;
        bresp_d = wacc ? (s_axilite_awaddr[4] ? RESP_SLVERR : RESP_OKAY) : bresp_q;
        irq_d   = |(isr_q & ier_q);
    end

    always_comb begin
        raddr   = {s_axilite_araddr[4:2], 2'b00};
        racc    = (rst_q == R_IDLE) && s_axilite_arvalid;
        rword   = (raddr == GPIO_IN_DATA_OFFSET) ? 32'(sync)  :
                  (raddr == GPIO_IN_IER_OFFSET)  ? 32'(ier_q) :
                  (raddr == GPIO_IN_ISR_OFFSET)  ? 32'(isr_q) :
                  (raddr == GPIO_IN_POL_OFFSET)  ? 32'(pol_q) : 32'h0;
        rdata_d = racc ? rword : rdata_q;
        rresp_d = racc ? (s_axilite_araddr[4] ? RESP_SLVERR : RESP_OKAY) : rresp_q;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wst_q   <= W_IDLE;
            rst_q   <= R_IDLE;
            ier_q   <= '0;
            isr_q   <= '0;
            pol_q   <= '0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            wst_q   <= wst_d;
            rst_q   <= rst_d;
            ier_q   <= ier_d;
            isr_q   <= isr_d;
            pol_q   <= pol_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign s_axilite_bresp = bresp_q;
    assign s_axilite_rdata = rdata_q;
    assign s_axilite_rresp = rresp_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_axilite_gpio_in.sv
// tb_axilite_gpio_in: directed and randomized checks of the GPIO-in peripheral against
// a transition-level model of the event register.
module tb_axilite_gpio_in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gpio = 16'hFFFF;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    axilite_gpio_in dut (
        .clock_i(clk), .reset_ni(rst_n), .gpio_in_i(gpio),
        .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid),
        .s_axilite_wready(wready), .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid),
        .s_axilite_bready(bready), .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid),
        .s_axilite_arready(arready), .s_axilite_rdata(rdata), .s_axilite_rresp(rresp),
        .s_axilite_rvalid(rvalid), .s_axilite_rready(rready), .irq_o(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("aw_timeout", 0, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("b_timeout", 0, 1);
        r = bresp;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("ar_timeout", 0, 1);
        @(negedge clk);
        arvalid = 0; rready = 1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("r_timeout", 0, 1);
        d = rdata; r = rresp;
        @(negedge clk);
        rready = 0;
    endtask

    logic [31:0] d, m;
    logic [1:0]  r;
    logic [15:0] m_in, m_new, m_isr, m_ier, m_pol, m_clr;
    logic [3:0]  s;

    initial begin
        #1;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_valids", {bvalid, rvalid, irq}, 0);
        check("rst_resps", {bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        wait_cycles(3);
        rst_n = 1;
        wait_cycles(10);
        axi_read(32'h08, d, r);
        check("arm_isr", d, 0);
        axi_read(32'h00, d, r);
        check("data_ffff", d, 32'h0000FFFF);
        check("data_resp", r, 2'b00);

        gpio = 16'hFFFE;
        wait_cycles(6);
        axi_write(32'h08, 32'hFFFF, 4'hF, r);
        axi_write(32'h04, 32'h1, 4'hF, r);
        check("ier_bresp", r, 2'b00);
        axi_write(32'h0C, 32'h0, 4'hF, r);
        @(negedge clk);
        gpio = 16'hFFFF;
        wait_cycles(3);
        check("irq_lat3", irq, 0);
        wait_cycles(1);
        check("irq_lat4", irq, 1);
        axi_read(32'h08, d, r);
        check("isr_rise", d, 32'h1);
        @(negedge clk);
        awaddr = 32'h08; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("irq_after_clr1", irq, 1);
        @(negedge clk);
        check("irq_after_clr2", irq, 0);
        bready = 1;
        @(negedge clk);
        bready = 0;

        gpio = 16'hFFFE;
        wait_cycles(6);
        gpio = 16'hFFFF;
        wait_cycles(2);
        awaddr = 32'h08; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        bready = 0;
        axi_read(32'h08, d, r);
        check("set_beats_clear", d, 32'h1);

        @(negedge clk);
        awaddr = 32'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only_ready", {awready, wready, bvalid}, 3'b110);
        end
        wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("b_hold", {bvalid, bresp, awready, wready}, 5'b10000);
            @(negedge clk);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("b_done", bvalid, 0);
        axi_read(32'h04, d, r);
        check("ier_once", d, 32'h5);

        axi_write(32'h08, 32'hFFFF, 4'hF, r);
        axi_write(32'h0C, 32'h2, 4'hF, r);
        gpio = 16'hFFFD;
        wait_cycles(6);
        axi_read(32'h08, d, r);
        check("pol_fall_set", d, 32'h2);
        axi_write(32'h08, 32'hFFFF, 4'hF, r);
        gpio = 16'hFFFF;
        wait_cycles(6);
        axi_read(32'h08, d, r);
        check("pol_rise_none", d, 32'h0);

        axi_read(32'h14, d, r);
        check("slverr_rresp", r, 2'b10);
        check("slverr_rdata", d, 0);
        axi_write(32'h18, 32'hFFFFFFFF, 4'hF, r);
        check("slverr_bresp", r, 2'b10);
        axi_write(32'h04, 32'hFFFFFFFF, 4'h1, r);
        axi_read(32'h04, d, r);
        check("ier_strb", d, 32'h000000FF);
        axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, r);
        axi_read(32'h0C, d, r);
        check("pol_width", d, 32'h0000FFFF);

        @(negedge clk);
        awaddr = 32'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("mid_bvalid", bvalid, 1);
        rst_n = 0;
        #1;
        check("mid_rst_b", {bvalid, awready, irq}, 3'b010);
        wait_cycles(2);
        rst_n = 1;
        wait_cycles(6);
        axi_read(32'h04, d, r);
        check("mid_rst_ier", d, 0);
        axi_read(32'h0C, d, r);
        check("mid_rst_pol", d, 0);

        m_in = gpio; m_isr = '0; m_ier = '0; m_pol = '0;
        for (int i = 0; i < 20; i++) begin
            m_pol = 16'($urandom);
            m_ier = 16'($urandom);
            axi_write(32'h0C, {16'h0, m_pol}, 4'hF, r);
            axi_write(32'h04, {16'h0, m_ier}, 4'hF, r);
            m_new = 16'($urandom);
            gpio = m_new;
            for (int b = 0; b < 16; b++)
                if (m_in[b] != m_new[b] && m_new[b] == ~m_pol[b]) m_isr[b] = 1'b1;
            m_in = m_new;
            wait_cycles(6);
            axi_read(32'h00, d, r);
            check("rnd_data", d, {16'h0, m_in});
            axi_read(32'h08, d, r);
            check("rnd_isr", d, {16'h0, m_isr});
            check("rnd_irq", irq, |(m_isr & m_ier));
            m = $urandom;
            s = 4'($urandom);
            m_clr = '0;
            for (int b = 0; b < 16; b++) m_clr[b] = m[b] & s[b / 8];
            axi_write(32'h08, m, s, r);
            m_isr = m_isr & ~m_clr;
            wait_cycles(2);
            check("rnd_irq_clr", irq, |(m_isr & m_ier));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
